// File: rtl/rv_mem_resp.sv
// rv_mem_resp: single-word memory responder with programmable wait states and on-chip RAM.
// One completion per accepted request; requests arriving while busy are dropped.
module rv_mem_resp #(
    parameter int DEPTH = 1024,
    parameter int WAIT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        memrw,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ack,
    output logic        err,
    output logic        busy
);
    localparam int AW = $clog2(DEPTH);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;
    state_t state;
    logic [3:0] cnt;
    logic wr_q;
    logic [31:0] addr_q, wdata_q;
    logic [31:0] mem [DEPTH];
    logic accept, access, acc_wr, bad;
    logic [31:0] acc_addr, acc_wdata;
    logic [AW-1:0] idx;
    assign accept = state == S_IDLE && req;
    // with no wait states the access uses the live request on the accept edge
    assign access = (accept && WAIT == 0) || (state == S_WAIT && cnt == 4'd1);
    assign acc_wr = accept ? memrw : wr_q;
    assign acc_addr = accept ? addr : addr_q;
    assign acc_wdata = accept ? wdata : wdata_q;
    assign idx = acc_addr[AW+1:2];
    assign bad = |acc_addr[1:0] || |acc_addr[31:AW+2];
    assign busy = state != S_IDLE;
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            cnt <= '0;
            ack <= 1'b0;
            err <= 1'b0;
            rdata <= '0;
            wr_q <= 1'b0;
            addr_q <= '0;
            wdata_q <= '0;
        end else begin
            ack <= access;
            err <= access && bad;
            if (access && (bad || !acc_wr))
                rdata <= bad ? '0 : mem[idx];
            if (accept) begin
                wr_q <= memrw;
                addr_q <= addr;
                wdata_q <= wdata;
                cnt <= 4'(WAIT);
            end else if (state == S_WAIT)
                cnt <= cnt - 4'd1;
            state <= access ? S_ACK : accept ? S_WAIT : state == S_ACK ? S_IDLE : state;
        end
    end
    // array is never cleared; reset only suppresses a pending write
    always_ff @(posedge clk) begin
        if (!rst && access && acc_wr && !bad)
            mem[idx] <= acc_wdata;
    end
endmodule

// File: doc/rv_mem_resp.md
# rv_mem_resp

Memory-side responder for the multicycle RISC-V core's memory port. It accepts single-word read/write requests issued by the control plane (`memrw` = 1 write, 0 read), models a programmable number of wait states, and returns one completion per request with a one-cycle `ack` pulse. It sits between the core's control/datapath and a word-organised on-chip RAM array, which is held inside this block.

## Interface

Parameters:
- `DEPTH`, 1024: number of 32-bit words; power of two, at least 4.
- `WAIT`, 2: wait-state cycles per access, range 0..15.

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `req`  in  1  request strobe; sampled only in IDLE.
- `memrw`  in  1  1 = write, 0 = read; sampled with `req`.
- `addr`  in  32  byte address; sampled with `req`.
- `wdata`  in  32  write data; sampled with `req`.
- `rdata`  out  32  read data; valid in the `ack` cycle and held until the next `ack`.
- `ack`  out  1  one-cycle completion pulse.
- `err`  out  1  asserted with `ack` when the access was rejected.
- `busy`  out  1  high while a request is in flight (state is not IDLE).

## Operation

- **FSM states:** IDLE, WAIT, ACK.
- **Accept:**
  - Accept occurs when the state is IDLE and `req`=1.
  - At that edge, latch `addr`, `wdata` and `memrw` into internal registers, and load `cnt` <= `WAIT`.
  - If `WAIT`=0, perform the access at the same edge and go to ACK. Otherwise go to WAIT.
- **WAIT state:**
  - `cnt` decrements by 1 each cycle.
  - At the edge where `cnt`==1, perform the access and go to ACK. The block therefore spends exactly `WAIT` cycles in WAIT.
- **ACK state:** `ack`=1 for exactly one cycle, then return to IDLE unconditionally.
- **Access rules:**
  - Word index = `addr[log2(DEPTH)+1:2]`.
  - `bad` = (`addr[1:0]` != 0) or (`addr` >= 4*`DEPTH`).
  - Write with !`bad`: the array word is updated.
  - Read with !`bad`: `rdata` is loaded with the array word.
  - `bad`: no array change, `rdata` <= 0, `err`=1 during the ACK cycle. Otherwise `err`=0.
- **Requests while busy:** `req` in WAIT or ACK is ignored, not queued, and has no side effects. The requester must hold or re-issue `req` after `busy` falls.
- **Array contents:** undefined after power-up and not cleared by `rst`.
- **Read-after-write:** a read after a completed write to the same word returns the new data.

## Timing

- **Reset values:** `rdata`=0, `ack`=0, `err`=0, `busy`=0, state IDLE, `cnt`=0.
- **Reset mid-operation:** `rst` in WAIT or ACK returns to IDLE at that edge.
  - If the access has not yet been performed (state WAIT), it is dropped: no array write and no `ack`.
  - If `rst` coincides with the access edge, reset wins: no write and no `ack`.
- **Latency:** `req` sampled in cycle 0 gives `busy`=1 in cycles 1..`WAIT`+1 and `ack` in cycle `WAIT`+1.
- **Throughput:** the next request can be accepted in cycle `WAIT`+2, giving one access per `WAIT`+2 cycles.
- **Output registering:** `ack`, `err` and `rdata` are registered. `busy` is decoded from the state register only, with no combinational path from inputs.
- **`rdata` on writes:** unchanged by a write `ack`. It changes only on a read `ack` or on an error `ack`.
- **Counter:** `cnt` is 4 bits with no wrap. The decrement never passes 0 because the exit is taken at 1.

## Test plan

1. **Reset:** drive `rst`=1 for 2 cycles with `req`=1 -> `ack`=0, `err`=0, `busy`=0, `rdata`=0x00000000. No accept occurs during reset.
2. **Write then read (`WAIT`=2):**
   - Write 0x12345678 to addr 0x10 with `req` in cycle 0 -> `busy` high in cycles 1..3, `ack` in cycle 3, `err`=0.
   - Read addr 0x10 in cycle 4 -> `ack` in cycle 7 with `rdata`=0x12345678.
3. **Zero wait states (`WAIT`=0):** read addr 0x0 in cycle 0 -> `ack` in cycle 1. A back-to-back request is accepted in cycle 2.
4. **Errors:**
   - Write 0xFFFFFFFF to addr 0x13 -> `ack`+`err`=1. A following read of 0x10 still returns 0x12345678.
   - Read addr 0x1000 (`DEPTH`=1024) -> `ack`+`err`=1, `rdata`=0.
5. **Busy ignore:** hold `req`=1 with a write to 0x20 in cycles 1..3 while a read of 0x10 is in flight -> only one `ack`, at cycle 3 (read data correct). The write is accepted in cycle 4 because `req` is still high in IDLE.
6. **Reset mid-access:** write 0xCAFEF00D to 0x20 with `req` in cycle 0 and assert `rst` in cycle 1 -> no `ack`. A later read of 0x20 returns the prior contents, not 0xCAFEF00D.
